// File: rtl/fetch_sequencer.sv
// Dual-issue fetch/issue controller: owns the fetch PC, splits 8-byte instruction
// pairs into even/odd issue slots, and sequences split issue and branch redirects.
module fetch_sequencer #(
    parameter int unsigned IMEM_BYTES = 2048,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] LNOP       = {11'b00000000001, 21'b0}
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] fetch_pc,
    output logic        fetch_stall,
    output logic        fetch_flush,
    input  logic        pair_valid,
    input  logic [31:0] pair_pc,
    input  logic [31:0] inst0,
    input  logic [31:0] inst1,
    input  logic        pipe_conflict,
    input  logic        issue_ready,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic [31:0] slot0_inst,
    output logic [31:0] slot1_inst,
    output logic        slot0_valid,
    output logic        slot1_valid,
    output logic [31:0] slot_pc
);

    localparam logic [31:0] PC_MASK  = 32'(IMEM_BYTES - 1);
    localparam logic [31:0] PAIR_MSK = PC_MASK & ~32'h7;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SPLIT,
        REDIRECT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        fetch_flush_q, fetch_flush_d;
    logic        slot0_valid_q, slot0_valid_d;
    logic        slot1_valid_q, slot1_valid_d;
    logic [31:0] slot0_inst_q, slot0_inst_d;
    logic [31:0] slot1_inst_q, slot1_inst_d;
    logic [31:0] slot_pc_q, slot_pc_d;
    logic        skip_first_q, skip_first_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc_q, hold_pc_d;

    logic        accept;
    logic [31:0] pc_next_seq;
    logic        redirect_now;

    assign accept       = pair_valid & issue_ready;
    assign pc_next_seq  = (fetch_pc_q + 32'd8) & PAIR_MSK;
    assign redirect_now = branch_valid & (state_q != IDLE);

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // branches below can leave one unassigned and infer a latch.
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_flush_d = 1'b0;
        slot0_valid_d = 1'b0;
        slot1_valid_d = 1'b0;
        slot0_inst_d  = LNOP;
        slot1_inst_d  = LNOP;
        slot_pc_d     = slot_pc_q;
        skip_first_d  = skip_first_q;
        hold_inst_d   = hold_inst_q;
        hold_pc_d     = hold_pc_q;

        if (redirect_now) begin
            // Big-endian bit 29 of the target is the odd-word select (bit 2 here).
            fetch_pc_d    = branch_target & PAIR_MSK;
            skip_first_d  = branch_target[2];
            hold_inst_d   = LNOP;
            hold_pc_d     = '0;
            fetch_flush_d = 1'b1;
            state_d       = REDIRECT;
        end else begin
            case (state_q)
                IDLE:     state_d = RUN;
                RUN: begin
                    if (accept) begin
                        slot_pc_d = pair_pc;
                        if (skip_first_q) begin
                            slot1_valid_d = 1'b1;
                            slot1_inst_d  = inst1;
                            skip_first_d  = 1'b0;
                            fetch_pc_d    = pc_next_seq;
                        end else if (pipe_conflict) begin
                            slot0_valid_d = 1'b1;
                            slot0_inst_d  = inst0;
                            hold_inst_d   = inst1;
                            hold_pc_d     = pair_pc;
                            state_d       = SPLIT;
                        end else begin
                            slot0_valid_d = 1'b1;
                            slot1_valid_d = 1'b1;
                            slot0_inst_d  = inst0;
                            slot1_inst_d  = inst1;
                            fetch_pc_d    = pc_next_seq;
                        end
                    end
                end
                SPLIT: begin
                    if (issue_ready) begin
                        slot1_valid_d = 1'b1;
                        slot1_inst_d  = hold_inst_q;
                        slot_pc_d     = hold_pc_q;
                        fetch_pc_d    = pc_next_seq;
                        state_d       = RUN;
                    end
                end
                REDIRECT: state_d = RUN;
            endcase
        end
    end

    assign fetch_stall = ~branch_valid &
                         ((state_q == SPLIT) | (state_q == REDIRECT) |
                          ((state_q == RUN) & pair_valid &
                           (~issue_ready | (pipe_conflict & ~skip_first_q))));

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the values computed before this edge.
        if (!reset) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC & PAIR_MSK;
            fetch_flush_q <= 1'b0;
            slot0_valid_q <= 1'b0;
            slot1_valid_q <= 1'b0;
            slot0_inst_q  <= LNOP;
            slot1_inst_q  <= LNOP;
            slot_pc_q     <= '0;
            skip_first_q  <= 1'b0;
            // NOTE: the hold buffer is a plain register, not a memory, so it is
            // cleared here to make a reset mid-split drop the held word.
            hold_inst_q   <= LNOP;
            hold_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_flush_q <= fetch_flush_d;
            slot0_valid_q <= slot0_valid_d;
            slot1_valid_q <= slot1_valid_d;
            slot0_inst_q  <= slot0_inst_d;
            slot1_inst_q  <= slot1_inst_d;
            slot_pc_q     <= slot_pc_d;
            skip_first_q  <= skip_first_d;
            hold_inst_q   <= hold_inst_d;
            hold_pc_q     <= hold_pc_d;
        end
    end

    assign fetch_pc    = fetch_pc_q;
    assign fetch_flush = fetch_flush_q;
    assign slot0_valid = slot0_valid_q;
    assign slot1_valid = slot1_valid_q;
    assign slot0_inst  = slot0_inst_q;
    assign slot1_inst  = slot1_inst_q;
    assign slot_pc     = slot_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, a hand-written split-stall
// sequence, and random traffic checked against a behavioural model.
module tb_fetch_sequencer;

    localparam int unsigned IMEM   = 2048;
    localparam logic [31:0] L      = 32'h0020_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic        fetch_stall;
    logic        fetch_flush;
    logic        pair_valid;
    logic [31:0] pair_pc;
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic        pipe_conflict;
    logic        issue_ready;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic [31:0] slot0_inst;
    logic [31:0] slot1_inst;
    logic        slot0_valid;
    logic        slot1_valid;
    logic [31:0] slot_pc;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .fetch_pc      (fetch_pc),
        .fetch_stall   (fetch_stall),
        .fetch_flush   (fetch_flush),
        .pair_valid    (pair_valid),
        .pair_pc       (pair_pc),
        .inst0         (inst0),
        .inst1         (inst1),
        .pipe_conflict (pipe_conflict),
        .issue_ready   (issue_ready),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .slot0_inst    (slot0_inst),
        .slot1_inst    (slot1_inst),
        .slot0_valid   (slot0_valid),
        .slot1_valid   (slot1_valid),
        .slot_pc       (slot_pc)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ia(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    function automatic logic [31:0] ib(input logic [31:0] pc);
        return 32'hB000_0000 | pc;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic pv, input logic [31:0] ppc,
                         input logic [31:0] i0, input logic [31:0] i1, input logic conf,
                         input logic rdy, input logic bv, input logic [31:0] bt);
        reset         = rst_n;
        pair_valid    = pv;
        pair_pc       = ppc;
        inst0         = i0;
        inst1         = i1;
        pipe_conflict = conf;
        issue_ready   = rdy;
        branch_valid  = bv;
        branch_target = bt;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic [31:0] e_fpc, input logic e_flush,
                              input logic e_v0, input logic [31:0] e_i0, input logic e_v1,
                              input logic [31:0] e_i1, input logic chk_spc, input logic [31:0] e_spc);
        check({tag, " fetch_pc"},    fetch_pc,           e_fpc);
        check({tag, " fetch_flush"}, 32'(fetch_flush),   32'(e_flush));
        check({tag, " slot0_valid"}, 32'(slot0_valid),   32'(e_v0));
        check({tag, " slot1_valid"}, 32'(slot1_valid),   32'(e_v1));
        check({tag, " slot0_inst"},  slot0_inst,         e_i0);
        check({tag, " slot1_inst"},  slot1_inst,         e_i1);
        if (chk_spc) check({tag, " slot_pc"}, slot_pc, e_spc);
    endtask

    typedef struct {
        logic        rst_n, pv;
        logic [31:0] ppc;
        logic        conf, rdy, bv;
        logic [31:0] bt;
        logic        e_stall;
        logic [31:0] e_fpc;
        logic        e_flush, e_v0;
        logic [31:0] e_i0;
        logic        e_v1;
        logic [31:0] e_i1, e_spc;
    } vec_t;

    function automatic vec_t mk(input logic rst_n, input logic pv, input logic [31:0] ppc,
                                input logic conf, input logic rdy, input logic bv,
                                input logic [31:0] bt, input logic e_stall, input logic [31:0] e_fpc,
                                input logic e_flush, input logic e_v0, input logic [31:0] e_i0,
                                input logic e_v1, input logic [31:0] e_i1, input logic [31:0] e_spc);
        vec_t v;
        v = '{rst_n, pv, ppc, conf, rdy, bv, bt, e_stall, e_fpc, e_flush, e_v0, e_i0, e_v1, e_i1, e_spc};
        return v;
    endfunction

    // Behavioural model: a queue of words awaiting odd-slot issue, a count of
    // blank cycles after a redirect, and a byte-address PC kept with modulo math.
    typedef struct { logic [31:0] word; logic [31:0] pc; } held_t;
    held_t       m_held[$];
    bit          m_started;
    int          m_blank;
    bit          m_skip;
    int unsigned m_pc;
    logic        x_flush, x_v0, x_v1;
    logic [31:0] x_i0, x_i1, x_spc;

    task automatic model_reset();
        m_started = 0;
        m_blank   = 0;
        m_skip    = 0;
        m_pc      = 0;
        m_held.delete();
        x_flush = 0; x_v0 = 0; x_v1 = 0; x_i0 = L; x_i1 = L; x_spc = 0;
    endtask

    function automatic logic model_stall(input logic pv, input logic conf, input logic rdy, input logic bv);
        if (bv) return 1'b0;
        if (!m_started) return 1'b0;
        if (m_held.size() != 0 || m_blank != 0) return 1'b1;
        return pv && (!rdy || (conf && !m_skip));
    endfunction

    task automatic model_step(input logic rst_n, input logic pv, input logic [31:0] ppc,
                              input logic [31:0] i0, input logic [31:0] i1, input logic conf,
                              input logic rdy, input logic bv, input logic [31:0] bt);
        if (!rst_n) begin
            model_reset();
            return;
        end
        x_flush = 0; x_v0 = 0; x_v1 = 0; x_i0 = L; x_i1 = L;
        if (!m_started) begin
            m_started = 1;
        end else if (bv) begin
            m_pc    = (bt - bt % 8) % IMEM;
            m_skip  = ((bt / 4) % 2) == 1;
            m_held.delete();
            m_blank = 1;
            x_flush = 1;
        end else if (m_blank != 0) begin
            m_blank = 0;
        end else if (m_held.size() != 0) begin
            if (rdy) begin
                x_v1  = 1;
                x_i1  = m_held[0].word;
                x_spc = m_held[0].pc;
                void'(m_held.pop_front());
                m_pc  = (m_pc + 8) % IMEM;
            end
        end else if (pv && rdy) begin
            x_spc = ppc;
            if (m_skip) begin
                x_v1 = 1; x_i1 = i1; m_skip = 0;
                m_pc = (m_pc + 8) % IMEM;
            end else if (conf) begin
                x_v0 = 1; x_i0 = i0;
                m_held.push_back('{i1, ppc});
            end else begin
                x_v0 = 1; x_i0 = i0; x_v1 = 1; x_i1 = i1;
                m_pc = (m_pc + 8) % IMEM;
            end
        end
    endtask

    initial begin
        vec_t vecs[$];
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check_regs("reset", 32'h0, 0, 0, L, 0, L, 1, 32'h0);

        //             rst pv ppc     cf rdy bv bt        | stall fpc    fl v0 i0           v1 i1           spc
        vecs.push_back(mk(1, 0, 32'h000, 0, 1, 0, 32'h000,   0, 32'h000, 0, 0, L,           0, L,           0));
        vecs.push_back(mk(1, 1, 32'h000, 0, 1, 0, 32'h000,   0, 32'h008, 0, 1, ia(32'h000), 1, ib(32'h000), 32'h000));
        vecs.push_back(mk(1, 1, 32'h008, 0, 1, 0, 32'h000,   0, 32'h010, 0, 1, ia(32'h008), 1, ib(32'h008), 32'h008));
        vecs.push_back(mk(1, 1, 32'h010, 0, 1, 0, 32'h000,   0, 32'h018, 0, 1, ia(32'h010), 1, ib(32'h010), 32'h010));
        vecs.push_back(mk(1, 1, 32'h018, 0, 1, 0, 32'h000,   0, 32'h020, 0, 1, ia(32'h018), 1, ib(32'h018), 32'h018));
        vecs.push_back(mk(1, 1, 32'h020, 1, 1, 0, 32'h000,   1, 32'h020, 0, 1, ia(32'h020), 0, L,           32'h020));
        vecs.push_back(mk(1, 0, 32'h020, 0, 1, 0, 32'h000,   1, 32'h028, 0, 0, L,           1, ib(32'h020), 32'h020));
        vecs.push_back(mk(1, 1, 32'h028, 0, 0, 0, 32'h000,   1, 32'h028, 0, 0, L,           0, L,           0));
        vecs.push_back(mk(1, 1, 32'h028, 0, 0, 0, 32'h000,   1, 32'h028, 0, 0, L,           0, L,           0));
        vecs.push_back(mk(1, 1, 32'h028, 0, 0, 0, 32'h000,   1, 32'h028, 0, 0, L,           0, L,           0));
        vecs.push_back(mk(1, 1, 32'h028, 0, 1, 0, 32'h000,   0, 32'h030, 0, 1, ia(32'h028), 1, ib(32'h028), 32'h028));
        vecs.push_back(mk(1, 1, 32'h030, 0, 1, 1, 32'h104,   0, 32'h100, 1, 0, L,           0, L,           0));
        vecs.push_back(mk(1, 1, 32'h030, 0, 1, 0, 32'h000,   1, 32'h100, 0, 0, L,           0, L,           0));
        vecs.push_back(mk(1, 1, 32'h100, 1, 1, 0, 32'h000,   0, 32'h108, 0, 0, L,           1, ib(32'h100), 32'h100));
        vecs.push_back(mk(1, 1, 32'h108, 1, 1, 0, 32'h000,   1, 32'h108, 0, 1, ia(32'h108), 0, L,           32'h108));
        vecs.push_back(mk(1, 0, 32'h000, 0, 1, 1, 32'h7F8,   0, 32'h7F8, 1, 0, L,           0, L,           0));
        vecs.push_back(mk(1, 0, 32'h000, 0, 1, 0, 32'h000,   1, 32'h7F8, 0, 0, L,           0, L,           0));
        vecs.push_back(mk(1, 1, 32'h7F8, 0, 1, 0, 32'h000,   0, 32'h000, 0, 1, ia(32'h7F8), 1, ib(32'h7F8), 32'h7F8));
        vecs.push_back(mk(1, 1, 32'h000, 0, 1, 1, 32'hA0C,   0, 32'h208, 1, 0, L,           0, L,           0));
        vecs.push_back(mk(1, 0, 32'h000, 0, 1, 1, 32'h330,   0, 32'h330, 1, 0, L,           0, L,           0));
        vecs.push_back(mk(1, 1, 32'h208, 0, 1, 0, 32'h000,   1, 32'h330, 0, 0, L,           0, L,           0));
        vecs.push_back(mk(1, 1, 32'h330, 0, 1, 0, 32'h000,   0, 32'h338, 0, 1, ia(32'h330), 1, ib(32'h330), 32'h330));
        vecs.push_back(mk(1, 1, 32'h338, 1, 1, 0, 32'h000,   1, 32'h338, 0, 1, ia(32'h338), 0, L,           32'h338));
        vecs.push_back(mk(0, 0, 32'h000, 0, 1, 0, 32'h000,   1, 32'h000, 0, 0, L,           0, L,           0));
        vecs.push_back(mk(1, 1, 32'h000, 0, 1, 0, 32'h000,   0, 32'h000, 0, 0, L,           0, L,           0));
        vecs.push_back(mk(0, 1, 32'h000, 0, 1, 1, 32'h104,   0, 32'h000, 0, 0, L,           0, L,           0));
        vecs.push_back(mk(1, 1, 32'h000, 0, 1, 1, 32'h104,   0, 32'h000, 0, 0, L,           0, L,           0));
        vecs.push_back(mk(1, 1, 32'h000, 0, 1, 0, 32'h000,   0, 32'h008, 0, 1, ia(32'h000), 1, ib(32'h000), 32'h000));

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].rst_n, vecs[i].pv, vecs[i].ppc, ia(vecs[i].ppc), ib(vecs[i].ppc),
                  vecs[i].conf, vecs[i].rdy, vecs[i].bv, vecs[i].bt);
            #1;
            check({tag, " fetch_stall"}, 32'(fetch_stall), 32'(vecs[i].e_stall));
            tick();
            check_regs(tag, vecs[i].e_fpc, vecs[i].e_flush, vecs[i].e_v0, vecs[i].e_i0,
                       vecs[i].e_v1, vecs[i].e_i1,
                       vecs[i].e_v0 | vecs[i].e_v1 | !vecs[i].rst_n, vecs[i].e_spc);
        end

        // Split with decode back-pressure: the held odd word waits, then issues alone.
        drive(1, 1, 32'h008, ia(32'h008), ib(32'h008), 1, 1, 0, 0);
        tick();
        check_regs("split_a", 32'h008, 0, 1, ia(32'h008), 0, L, 1, 32'h008);
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 32'h010, ia(32'h010), ib(32'h010), 0, 0, 0, 0);
            #1;
            check("split_wait fetch_stall", 32'(fetch_stall), 32'h1);
            tick();
            check_regs("split_wait", 32'h008, 0, 0, L, 0, L, 0, 32'h0);
        end
        drive(1, 1, 32'h010, ia(32'h010), ib(32'h010), 0, 1, 0, 0);
        tick();
        check_regs("split_b", 32'h010, 0, 0, L, 1, ib(32'h008), 1, 32'h008);

        // Random traffic against the model.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic        r_rst, r_pv, r_conf, r_rdy, r_bv;
            logic [31:0] r_ppc, r_i0, r_i1, r_bt;
            logic        e_stall;
            r_rst  = ($urandom_range(63) != 0);
            r_pv   = ($urandom_range(3) != 0);
            r_conf = ($urandom_range(3) == 0);
            r_rdy  = ($urandom_range(3) != 0);
            r_bv   = ($urandom_range(15) == 0);
            r_bt   = ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'h0000_07FC);
            r_ppc  = m_pc;
            r_i0   = $urandom;
            r_i1   = $urandom;
            e_stall = model_stall(r_pv, r_conf, r_rdy, r_bv);
            drive(r_rst, r_pv, r_ppc, r_i0, r_i1, r_conf, r_rdy, r_bv, r_bt);
            #1;
            check("rand fetch_stall", 32'(fetch_stall), 32'(e_stall));
            model_step(r_rst, r_pv, r_ppc, r_i0, r_i1, r_conf, r_rdy, r_bv, r_bt);
            tick();
            check_regs("rand", m_pc, x_flush, x_v0, x_i0, x_v1, x_i1,
                       x_v0 | x_v1 | !r_rst, x_spc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
